// File: rtl/stopwatch_pkg.sv
// Package: stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   state_t              - FSM state encoding, also driven onto the 2-bit state port
//                          (IDLE=00, RUN=01, PAUSE=10, LAP=11)
//   DEB_CYCLES_DEFAULT   - stable samples to accept a button level (20 ms at 100 MHz)
//   TICK_DIV_DEFAULT     - clk cycles per count tick (10 ms at 100 MHz)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    localparam int DEB_CYCLES_DEFAULT = 2_000_000;
    localparam int TICK_DIV_DEFAULT   = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Module: btn_debounce
// Conditions one active-low asynchronous push button:
// 2-flop synchronizer -> run-length debouncer -> registered press pulse.
// Ports:
//   clk    in  sole clock, rising edge
//   rst    in  synchronous active-high reset
//   btn_n  in  raw button, active-low, idle high
//   press  out one-cycle pulse on each debounced 1->0 transition
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic          armed;
    logic [1:0]    settle;
    logic [CW-1:0] run_cnt;

    // The debounced level flips on the edge that sees the DEB_CYCLES-th
    // consecutive differing sample; a shorter differing run is dropped.
    //
    // The synchronizer flops come out of reset at 1, so the first two sync_b
    // samples after reset do not reflect the pin. 'settle' marks when they do.
    // 'armed' is only set once the button has been genuinely seen released,
    // which keeps a button held down through reset from producing a press
    // until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            run_cnt <= '0;
            settle  <= 2'b00;
            armed   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_a  <= btn_n;
            sync_b  <= sync_a;
            settle  <= {settle[0], 1'b1};
            level_d <= level;

            if (sync_b != level) begin
                if (run_cnt == CNT_LAST) begin
                    level   <= sync_b;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + CW'(1);
                end
            end else begin
                run_cnt <= '0;
            end

            if (settle[1] && level && sync_b) begin
                armed <= 1'b1;
            end

            press <= armed && level_d && !level;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Module: stopwatch_ctrl
// Stopwatch control FSM with debounced buttons and a count-tick prescaler.
// Optional lap feature: define STOPWATCH_LAP_EN to add the lap_n button,
// its debouncer and the LAP state. Without it LAP is unreachable and
// disp_hold is constant 0; the state encoding does not change.
// Ports:
//   clk           in  sole clock, rising edge
//   rst           in  synchronous active-high reset
//   start_stop_n  in  start/stop button, active-low, asynchronous
//   clear_n       in  clear button, active-low, asynchronous
//   lap_n         in  lap button, active-low, asynchronous (STOPWATCH_LAP_EN only)
//   cnt_en        out one-cycle tick to the time counter
//   cnt_clr       out one-cycle clear to the time counter
//   disp_hold     out freeze display latch while in LAP
//   state         out current state (IDLE=00, RUN=01, PAUSE=10, LAP=11)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int TICK_DIV   = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop_n,
    input  logic       clear_n,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap_n,
`endif
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q;
    state_t        state_nxt;
    logic          clr_nxt;
    logic          ss_press;
    logic          clr_press;
    logic          lap_press;
    logic          run_now;
    logic          run_next;
    logic [PW-1:0] presc;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start_stop (
        .clk   (clk),
        .rst   (rst),
        .btn_n (start_stop_n),
        .press (ss_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk   (clk),
        .rst   (rst),
        .btn_n (clear_n),
        .press (clr_press)
    );

`ifdef STOPWATCH_LAP_EN
    logic hold_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk   (clk),
        .rst   (rst),
        .btn_n (lap_n),
        .press (lap_press)
    );

    assign disp_hold = hold_q;
`else
    assign lap_press = 1'b0;
    assign disp_hold = 1'b0;
`endif

    assign state    = state_q;
    assign run_now  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign run_next = (state_nxt == ST_RUN) || (state_nxt == ST_LAP);

    // Next-state logic. Clear wins over start/stop in IDLE/PAUSE; start/stop
    // wins over lap in RUN/LAP.
    always_comb begin
        state_nxt = state_q;
        clr_nxt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_press) begin
                    clr_nxt = 1'b1;
                end else if (ss_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (clr_press) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end else if (ss_press) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_LAP: begin
                if (ss_press) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_press) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_clr <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            hold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            cnt_clr <= clr_nxt;
`ifdef STOPWATCH_LAP_EN
            hold_q  <= (state_nxt == ST_LAP);
`endif
        end
    end

    // Prescaler advances while the current state is RUN/LAP and holds in
    // PAUSE. cnt_en is qualified with the next state so no tick is issued on
    // the edge that enters PAUSE; a wrap landing on that edge loses its tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            cnt_en <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            if (state_nxt == ST_IDLE) begin
                presc <= '0;
            end else if (run_now) begin
                if (presc == PRESC_LAST) begin
                    presc  <= '0;
                    cnt_en <= run_next;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench: tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=10.
// Builds with or without STOPWATCH_LAP_EN; the lap port and lap vectors
// follow the same macro.
module tb_stopwatch_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int LAT  = DEB + 4;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    typedef struct {
        logic       ss_n;
        logic       clr_n;
        logic       lap_n;
        int         low;
        logic [1:0] st;
        int         clr;
        int         ticks;
        logic       hold;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        int         clr;
        int         ticks;
        logic       hold;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop_n = 1'b1;
    logic       clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    logic       lap_n = 1'b1;
`endif
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_hold;
    logic [1:0] state;

    int n_cmp = 0;
    int n_fail = 0;
    int clr_total = 0;
    int tick_total = 0;
    int viol = 0;

    vec_t vecs[$];
    exp_t sb_q[$];

    stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_stop_n (start_stop_n),
        .clear_n      (clear_n),
`ifdef STOPWATCH_LAP_EN
        .lap_n        (lap_n),
`endif
        .cnt_en       (cnt_en),
        .cnt_clr      (cnt_clr),
        .disp_hold    (disp_hold),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Output monitor: pulse counters plus invariants checked every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (cnt_clr) clr_total++;
            if (cnt_en) tick_total++;
            if (cnt_en && (state == S_IDLE || state == S_PAUSE)) viol++;
            if (disp_hold != (state == S_LAP)) viol++;
`ifndef STOPWATCH_LAP_EN
            if (state == S_LAP) viol++;
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic waitState(input logic [1:0] want, output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (state == want) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic waitTick(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (cnt_en) begin
                n = i;
                break;
            end
        end
    endtask

    // Start/stop press of 8 cycles beginning just after the next edge.
    task automatic pressStart();
        @(posedge clk);
        #1 start_stop_n = 1'b0;
        fork
            begin
                repeat (8) @(posedge clk);
                #1 start_stop_n = 1'b1;
            end
        join_none
    endtask

    function automatic void addVec(input logic ss, input logic cl, input logic lp, input int low,
                                   input logic [1:0] st, input int clr, input int ticks, input logic hold);
        vec_t v;
        v = '{ss, cl, lp, low, st, clr, ticks, hold};
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input int clr_act, input int ticks_act);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            n_cmp--;
            e = sb_q.pop_front();
            check({e.name, " state"}, int'(state), int'(e.st));
            check({e.name, " cnt_clr pulses"}, clr_act, e.clr);
            check({e.name, " cnt_en pulses"}, ticks_act, e.ticks);
            check({e.name, " disp_hold"}, int'(disp_hold), int'(e.hold));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        int c0, t0, t1, c1;
        e.name  = $sformatf("vec%0d", idx);
        e.st    = v.st;
        e.clr   = v.clr;
        e.ticks = v.ticks;
        e.hold  = v.hold;
        sb_q.push_back(e);
        c0 = clr_total;
        @(posedge clk);
        #1;
        start_stop_n = v.ss_n;
        clear_n      = v.clr_n;
`ifdef STOPWATCH_LAP_EN
        lap_n        = v.lap_n;
`endif
        repeat (v.low) @(posedge clk);
        #1;
        start_stop_n = 1'b1;
        clear_n      = 1'b1;
`ifdef STOPWATCH_LAP_EN
        lap_n        = 1'b1;
`endif
        repeat (14 - v.low) @(posedge clk);
        t0 = tick_total;
        repeat (20) @(posedge clk);
        t1 = tick_total;
        c1 = clr_total;
        @(negedge clk);
        checkOutput(c1 - c0, t1 - t0);
    endtask

    initial begin
        int n;
        int t0;

        // {ss_n, clr_n, lap_n, low, state, clr pulses, ticks in 20 cycles, hold}
        addVec(1, 0, 1, 8, S_IDLE,  1, 0, 0);
        addVec(0, 1, 1, 3, S_IDLE,  0, 0, 0);
        addVec(0, 1, 1, 8, S_RUN,   0, 2, 0);
        addVec(1, 0, 1, 8, S_RUN,   0, 2, 0);
        addVec(0, 1, 1, 8, S_PAUSE, 0, 0, 0);
        addVec(0, 1, 1, 8, S_RUN,   0, 2, 0);
        addVec(0, 1, 1, 8, S_PAUSE, 0, 0, 0);
        addVec(0, 0, 1, 8, S_IDLE,  1, 0, 0);
        addVec(0, 0, 1, 8, S_IDLE,  1, 0, 0);
        addVec(0, 1, 1, 8, S_RUN,   0, 2, 0);
`ifdef STOPWATCH_LAP_EN
        addVec(1, 1, 0, 8, S_LAP,   0, 2, 1);
        addVec(1, 0, 1, 8, S_LAP,   0, 2, 1);
        addVec(1, 1, 0, 8, S_RUN,   0, 2, 0);
        addVec(0, 1, 0, 8, S_PAUSE, 0, 0, 0);
        addVec(0, 1, 1, 8, S_RUN,   0, 2, 0);
        addVec(1, 1, 0, 8, S_LAP,   0, 2, 1);
        addVec(0, 1, 0, 8, S_PAUSE, 0, 0, 0);
        addVec(0, 1, 1, 8, S_RUN,   0, 2, 0);
        addVec(1, 1, 0, 8, S_LAP,   0, 2, 1);
`else
        addVec(1, 1, 0, 8, S_RUN,   0, 2, 0);
        addVec(0, 1, 1, 8, S_PAUSE, 0, 0, 0);
        addVec(1, 0, 1, 8, S_IDLE,  1, 0, 0);
`endif

        // Power-on reset, then 100 quiet cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", int'(state), int'(S_IDLE));
        check("reset cnt_en", int'(cnt_en), 0);
        check("reset cnt_clr", int'(cnt_clr), 0);
        check("reset disp_hold", int'(disp_hold), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        t0 = tick_total;
        repeat (100) @(posedge clk);
        check("idle ticks over 100 cycles", tick_total - t0, 0);

        // Press latency and tick period; button held low 20 cycles.
        @(posedge clk);
        #1 start_stop_n = 1'b0;
        fork
            begin
                repeat (20) @(posedge clk);
                #1 start_stop_n = 1'b1;
            end
        join_none
        waitState(S_RUN, n);
        check("start latency edges", n, LAT);
        waitTick(n);
        check("first tick after RUN", n, TDIV);
        waitTick(n);
        check("tick period", n, TDIV);

        // Reset in the middle of RUN.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun reset state", int'(state), int'(S_IDLE));
        check("midrun reset cnt_en", int'(cnt_en), 0);
        check("midrun reset cnt_clr", int'(cnt_clr), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);

        // 25 cycles of RUN, pause, resume: 5 prescaler counts remain.
        pressStart();
        waitState(S_RUN, n);
        check("run entry latency", n, LAT);
        repeat (17) @(posedge clk);
        #1 start_stop_n = 1'b0;
        fork
            begin
                repeat (8) @(posedge clk);
                #1 start_stop_n = 1'b1;
            end
        join_none
        waitState(S_PAUSE, n);
        check("pause after 25 run cycles", n, LAT);
        t0 = tick_total;
        repeat (30) @(posedge clk);
        check("ticks during PAUSE", tick_total - t0, 0);
        pressStart();
        waitState(S_RUN, n);
        check("resume latency", n, LAT);
        waitTick(n);
        check("ticks to first cnt_en after resume", n, TDIV - (25 % TDIV));

        // Pause with a part-filled prescaler, then clear+start together.
        pressStart();
        waitState(S_PAUSE, n);
        check("second pause latency", n, LAT);
        applyStimulus('{1'b0, 1'b0, 1'b1, 8, S_IDLE, 1, 0, 1'b0}, 100);
        pressStart();
        waitState(S_RUN, n);
        check("run after clear latency", n, LAT);
        waitTick(n);
        check("prescaler zeroed by clear", n, TDIV);

        // Button held through reset must be released before it counts.
        @(posedge clk);
        #1 start_stop_n = 1'b0;
        doReset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("held through reset state", int'(state), int'(S_IDLE));
        @(posedge clk);
        #1 start_stop_n = 1'b1;
        repeat (12) @(posedge clk);
        pressStart();
        waitState(S_RUN, n);
        check("re-press after reset latency", n, LAT);

        // Table-driven vectors from a fresh IDLE.
        doReset();
        repeat (6) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

`ifdef STOPWATCH_LAP_EN
        // Reset asserted while in LAP.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lap reset state", int'(state), int'(S_IDLE));
        check("lap reset disp_hold", int'(disp_hold), 0);
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        check("invariant violations", viol, 0);
        check("scoreboard leftover", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
